dmem: RTL
=========

# dmem

Single-port data memory with a fixed, parameterised access latency, directly downstream of the MEM stage. It consumes the MEM stage's memory request (address, write data, read/write strobes) and returns read data to it. It raises a stall while an access is in flight so the pipeline holds the request stable. It accepts one word access at a time through a three-state FSM.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two; `AW = log2(DEPTH_WORDS)`.
- `LAT`, default 2: wait cycles between acceptance and completion; range 0..15.
- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `i_MEM_mem_DmemAddr` in 32: byte address; word index = `addr[AW+1:2]`.
- `i_MEM_mem_DmemDataW` in 32: write data.
- `i_MEM_mem_MemRead` in 1: read request.
- `i_MEM_mem_MemWrite` in 1: write request.
- `o_MEM_mem_DmemDataR` out 32: read data, valid in the DONE cycle.
- `o_MEM_ctrl_Stall` out 1: pipeline hold request to the hazard logic.
- `o_MEM_ctrl_Misalign` out 1: misaligned-access flag, one-cycle pulse in DONE.

## Operation
- `req = MemRead | MemWrite`.
- FSM states: IDLE, WAIT, DONE.
- IDLE
  - `req=1` latches the request into internal registers (addr, data, write flag) and loads the counter with LAT.
  - Next state is WAIT if LAT>0, otherwise DONE.
  - `req=0` stays in IDLE.
- WAIT
  - Counter decrements by 1 each cycle.
  - When the counter equals 1, the next state is DONE.
- Edge entering DONE (the commit edge)
  - A write updates the array.
  - A read captures `array[index]` into the DataR register.
- DONE
  - Lasts exactly one cycle, then returns to IDLE unconditionally.
  - Inputs are ignored in DONE: the held request is not re-accepted.
- Stall is combinational: `(IDLE & req) | WAIT`. It is 0 in DONE, which lets the pipeline advance and capture DataR.
- `MemRead & MemWrite` together is treated as a write. DataR returns the pre-write word (read-before-write).
- Addresses at or above `DEPTH_WORDS*4` wrap: upper bits are ignored.
- Array contents are not initialised or reset.
- Request inputs are required to be stable while Stall=1. Inputs are only sampled in IDLE.

## Timing
- Reset values: state IDLE, counter 0, DataR 0, Misalign 0, Stall = `req` (combinational).
- Per access: stall cycles = LAT+1; total cycles from acceptance to IDLE = LAT+2.
- DataR holds its last read value outside DONE. Writes do not change DataR except in the simultaneous read/write case.
- Back-to-back: a new request can be accepted in the IDLE cycle immediately after DONE.
- Asynchronous reset mid-access:
  - Immediate return to IDLE.
  - A pending write is dropped, so the array is unchanged.
  - DataR is forced to 0.

## Configuration
- Macro: `DMEM_ALIGN_CHECK_EN`.
- Defined
  - A request with `addr[1:0] != 0` completes with normal timing.
  - A write is suppressed.
  - DataR is loaded with 0.
  - `o_MEM_ctrl_Misalign` is 1 for the DONE cycle.
- Undefined
  - `addr[1:0]` is ignored.
  - `o_MEM_ctrl_Misalign` is tied to 0.
  - No alignment logic is built.

## Structure
- `dmem_pkg` holds:
  - the state enum (IDLE/WAIT/DONE),
  - `DMEM_WORD_W = 32`,
  - the counter width constant (4 bits).
- Sub-module `dmem_array`: synchronous single-port RAM with ports we, addr[AW-1:0], wdata, rdata. Registered read, read-before-write.
- FSM, counter, request latch and alignment check live in the `dmem` top.

## Test plan
- Write then read, LAT=2:
  - Write 0xDEADBEEF to 0x10; Stall high for 3 cycles.
  - Read 0x10; DataR = 0xDEADBEEF in the DONE cycle (cycle 4 after acceptance).
- LAT=0: a read of a preloaded word gives Stall for 1 cycle and DataR valid on the next cycle; back-to-back reads accepted every 2 cycles.
- Simultaneous MemRead+MemWrite to 0x20 (old 0x11111111, new 0x22222222):
  - DataR = 0x11111111.
  - A subsequent read returns 0x22222222.
- Async reset asserted during WAIT of a write of 0xCAFEF00D to 0x30:
  - Next cycle in IDLE, DataR = 0.
  - A later read of 0x30 returns the old contents.
- Address wrap (DEPTH_WORDS=1024): write 0xA5A5A5A5 to 0x1004, read 0x0004 -> 0xA5A5A5A5.
- `DMEM_ALIGN_CHECK_EN` defined:
  - Write to 0x0042: Misalign = 1 in DONE only; word 0x40 unchanged.
  - Read to 0x0041: DataR = 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem shared types and constants.
// State encoding, word width and wait-counter width.
package dmem_pkg;

  localparam int DMEM_WORD_W = 32;
  localparam int DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// dmem storage: synchronous single-port RAM.
// Registered read returns the word as it was before a same-edge write.
import dmem_pkg::*;

module dmem_array #(
  parameter int AW = 10
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          addr,
  input  logic [DMEM_WORD_W-1:0] wdata,
  output logic [DMEM_WORD_W-1:0] rdata
);

  logic [DMEM_WORD_W-1:0] mem [0:(1<<AW)-1];

  // write on we; read register always samples the old word
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem.sv
// dmem: fixed-latency data memory behind the MEM stage.
// Define DMEM_ALIGN_CHECK_EN to flag and squash misaligned accesses.
import dmem_pkg::*;

module dmem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LAT         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_MEM_mem_DmemAddr,
  input  logic [31:0] i_MEM_mem_DmemDataW,
  input  logic        i_MEM_mem_MemRead,
  input  logic        i_MEM_mem_MemWrite,
  output logic [31:0] o_MEM_mem_DmemDataR,
  output logic        o_MEM_ctrl_Stall,
  output logic        o_MEM_ctrl_Misalign
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [DMEM_CNT_W-1:0] LAT_C =
    DMEM_CNT_W'(LAT);

  dmem_state_e state_q;
  dmem_state_e state_d;

  logic [DMEM_CNT_W-1:0]  cnt_q;
  logic [AW-1:0]          addr_q;
  logic [DMEM_WORD_W-1:0] wdata_q;
  logic                   wr_q;
  logic                   rd_q;
  logic                   mis_q;
  logic [DMEM_WORD_W-1:0] hold_q;

  logic                   req;
  logic                   idle;
  logic                   commit;
  logic                   stall;
  logic [AW-1:0]          a_idx;
  logic [DMEM_WORD_W-1:0] a_wdata;
  logic                   a_wr;
  logic                   a_mis;
  logic                   we;
  logic [DMEM_WORD_W-1:0] arr_rdata;
  logic                   ld;
  logic [DMEM_WORD_W-1:0] dval;
  logic                   unused_addr;

  assign req  = i_MEM_mem_MemRead | i_MEM_mem_MemWrite;
  assign idle = (state_q == IDLE);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state, stall and commit strobe
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          stall = 1'b1;
          if (LAT_C == '0) begin
            state_d = DONE;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt_q == DMEM_CNT_W'(1)) begin
          state_d = DONE;
          commit  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // request latch and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else if (idle && req) begin
      cnt_q   <= LAT_C;
      addr_q  <= i_MEM_mem_DmemAddr[AW+1:2];
      wdata_q <= i_MEM_mem_DmemDataW;
      wr_q    <= i_MEM_mem_MemWrite;
      rd_q    <= i_MEM_mem_MemRead;
    end else if (state_q == WAIT) begin
      cnt_q   <= cnt_q - DMEM_CNT_W'(1);
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  // misalignment flag for the access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (idle && req) begin
      mis_q <= |i_MEM_mem_DmemAddr[1:0];
    end
  end

  assign a_mis = idle ? |i_MEM_mem_DmemAddr[1:0]
                      : mis_q;
  assign o_MEM_ctrl_Misalign =
    (state_q == DONE) & mis_q;
`else
  assign mis_q = 1'b0;
  assign a_mis = 1'b0;
  assign o_MEM_ctrl_Misalign = 1'b0;
`endif

  // with LAT=0 the commit edge is the accept edge,
  // so the array sees live inputs while idle
  assign a_idx   = idle ? i_MEM_mem_DmemAddr[AW+1:2]
                        : addr_q;
  assign a_wdata = idle ? i_MEM_mem_DmemDataW
                        : wdata_q;
  assign a_wr    = idle ? i_MEM_mem_MemWrite : wr_q;
  assign we      = commit & a_wr & ~a_mis;

  dmem_array #(
    .AW(AW)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .addr (a_idx),
    .wdata(a_wdata),
    .rdata(arr_rdata)
  );

  assign ld   = rd_q | mis_q;
  assign dval = mis_q ? '0 : arr_rdata;

  // keep the last returned word outside DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if ((state_q == DONE) && ld) begin
      hold_q <= dval;
    end
  end

  assign o_MEM_mem_DmemDataR =
    ((state_q == DONE) && ld) ? dval : hold_q;
  assign o_MEM_ctrl_Stall = stall;

  assign unused_addr = &{1'b0,
                         i_MEM_mem_DmemAddr[31:AW+2],
                         i_MEM_mem_DmemAddr[1:0]};

endmodule
